im_loader: RTL
==============

Name: im_loader

Overview:
- Program loader that fills the instruction memory, i.e. the write side of the instruction fetch path, before the CPU is released to run.
- Accepts a byte stream over a valid/ready handshake, starting with a 16-bit instruction count.
- Assembles each group of 4 bytes into one 26-bit instruction word and writes it to consecutive IM word addresses.
- On completion, asserts CPU_START so the core begins fetching at PC 0.

Parameters:
- INSTR_W, 26, instruction word width written to IM.
- ADDR_W, 16, IM word-address width (matches the PC width).
- BASE_ADDR, 0, IM word address of the first instruction.
- MAX_WORDS, 1024, largest count accepted; larger counts go to ERR.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous and active-high.
- LOAD  input  1  load request; sampled only in IDLE, DONE and ERR.
- IN_DATA  input  8  stream byte.
- IN_VALID  input  1  IN_DATA is valid.
- IN_READY  output  1  loader accepts a byte this cycle.
- IM_WE  output  1  IM write strobe, exactly one cycle per word.
- IM_ADDR  output  ADDR_W  IM word address.
- IM_WDATA  output  INSTR_W  instruction word.
- CPU_START  output  1  high means the CPU runs; low holds the CPU at PC 0.
- BUSY  output  1  a load is in progress.
- ERROR  output  1  the last load was rejected.
- WORD_CNT  output  ADDR_W  number of words written so far in the current load.

Behaviour:
- Reset (asynchronous): state=IDLE. Every output is 0: IN_READY, IM_WE, IM_ADDR, IM_WDATA, CPU_START, BUSY, ERROR, WORD_CNT. Internal count, index and byte counter are also 0.
- A byte transfers only in a cycle where IN_VALID and IN_READY are both 1. IN_DATA is not sampled otherwise. IN_READY is a registered function of state only and never depends on IN_VALID.
- States: IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR.
- IDLE, DONE and ERR, with LOAD=1:
  - next state HDR_HI;
  - CPU_START<=0, ERROR<=0, WORD_CNT<=0, index<=0, BUSY<=1.
  - In DONE and ERR with LOAD=0, the state holds.
- HDR_HI: IN_READY=1. On transfer, count[15:8]<=IN_DATA, go to HDR_LO.
- HDR_LO: IN_READY=1. On transfer, count[7:0]<=IN_DATA, then:
  - count==0: go to DONE.
  - count>MAX_WORDS: go to ERR.
  - otherwise: go to DATA with byte counter=0.
- DATA: IN_READY=1. Bytes are big-endian.
  - byte 0 supplies bits [25:24] from IN_DATA[1:0]; IN_DATA[7:2] are ignored.
  - byte 1 supplies [23:16], byte 2 supplies [15:8], byte 3 supplies [7:0].
  - After byte 3 transfers, go to WRITE.
- WRITE: IN_READY=0. For exactly one cycle:
  - IM_WE=1, IM_ADDR=BASE_ADDR+index (mod 2^ADDR_W), IM_WDATA=assembled word.
  - At the end of the cycle, WORD_CNT and index increment.
  - If index+1==count, go to DONE; otherwise go to DATA with byte counter=0.
- DONE: BUSY=0, CPU_START=1, IN_READY=0. CPU_START stays high until the next LOAD or RST.
- ERR: BUSY=0, ERROR=1, CPU_START=0, IN_READY=0.
- IM_WE, IN_READY, CPU_START, BUSY and ERROR are registered. IM_ADDR and IM_WDATA are stable in the IM_WE cycle; outside it they hold their last value.
- Throughput: at most one word per 5 cycles (4 byte transfers plus 1 write cycle). IN_VALID gaps stall the loader without loss of state.
- LOAD while BUSY=1 is ignored.
- RST mid-load: the loader returns to IDLE immediately and drives CPU_START=0. Words already written stay in IM; no partial word is written.
- A word is written only after all 4 of its bytes have been transferred.

Test Plan:
- Reset then idle: all outputs 0 and IN_READY=0. With LOAD=0 and IN_VALID=1 for 10 cycles, no IM_WE pulse occurs.
- LOAD, then stream 00 02 | 03 12 34 56 | 00 00 00 01 with IN_VALID held high:
  - IM_WE pulses at addr 0 with data 26'h3123456, then at addr 1 with data 26'h0000001;
  - the pulses are 5 cycles apart;
  - then CPU_START=1, WORD_CNT=2, BUSY=0.
- Same stream with IN_VALID toggling 1/0 every cycle: identical writes, each word spaced by the stalls. Byte 0 = FF yields bits [25:24]=2'b11 with the upper bits ignored.
- Header 00 00 gives DONE with no IM_WE and CPU_START=1. Header 04 01 (1025 > MAX_WORDS) gives ERROR=1, CPU_START=0, no IM_WE. A following LOAD clears ERROR.
- RST asserted after 2 bytes of word 1 in a 3-word load:
  - outputs go to 0 asynchronously, before the next edge;
  - only word 0 has been written;
  - a reload then works normally.
- LOAD pulsed during DATA: no effect. BASE_ADDR=16'hFFFF with 2 words: writes go to FFFF, then wrap to 0000.

Source files
------------

// File: rtl/im_loader.sv
// Program loader: takes a 16-bit instruction count and then 4 bytes per instruction
// over valid/ready, writes 26-bit words to IM and releases the CPU when the load completes.
module im_loader #(
    parameter int unsigned       INSTR_W   = 26,
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       MAX_WORDS = 1024
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               LOAD,
    input  logic [7:0]         IN_DATA,
    input  logic               IN_VALID,
    output logic               IN_READY,
    output logic               IM_WE,
    output logic [ADDR_W-1:0]  IM_ADDR,
    output logic [INSTR_W-1:0] IM_WDATA,
    output logic               CPU_START,
    output logic               BUSY,
    output logic               ERROR,
    output logic [ADDR_W-1:0]  WORD_CNT
);

    // Handshake: a byte moves on a rising edge where IN_VALID and IN_READY are both 1.
    // IN_READY comes from a flop that only tracks the state, never IN_VALID.
    typedef enum logic [2:0] {
        IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR
    } state_e;

    localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

    state_e              state_q, state_d;
    logic [15:0]         count_q, count_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [INSTR_W-1:0]  word_q, word_d;
    logic                in_ready_q, in_ready_d;
    logic                im_we_q, im_we_d;
    logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
    logic [INSTR_W-1:0]  im_wdata_q, im_wdata_d;
    logic                cpu_start_q, cpu_start_d;
    logic                busy_q, busy_d;
    logic                error_q, error_d;
    logic                xfer;
    logic [ADDR_W-1:0]   idx_inc;

    assign xfer    = IN_VALID && in_ready_q;
    assign idx_inc = idx_q + ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        bcnt_d      = bcnt_q;
        word_d      = word_q;
        in_ready_d  = in_ready_q;
        im_we_d     = 1'b0;
        im_addr_d   = im_addr_q;
        im_wdata_d  = im_wdata_q;
        cpu_start_d = cpu_start_q;
        busy_d      = busy_q;
        error_d     = error_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (LOAD) begin
                    state_d     = HDR_HI;
                    in_ready_d  = 1'b1;
                    cpu_start_d = 1'b0;
                    error_d     = 1'b0;
                    idx_d       = '0;
                    busy_d      = 1'b1;
                end
            end
            HDR_HI: begin
                if (xfer) begin
                    count_d[15:8] = IN_DATA;
                    state_d       = HDR_LO;
                end
            end
            HDR_LO: begin
                if (xfer) begin
                    count_d = {count_q[15:8], IN_DATA};
                    if (count_d == 16'd0) begin
                        state_d     = DONE;
                        in_ready_d  = 1'b0;
                        busy_d      = 1'b0;
                        cpu_start_d = 1'b1;
                    end else if (count_d > MAX_CNT) begin
                        state_d    = ERR;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b0;
                        error_d    = 1'b1;
                    end else begin
                        state_d = DATA;
                        bcnt_d  = 2'd0;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    // Big-endian: byte 0 only carries the top INSTR_W-24 bits.
                    case (bcnt_q)
                        2'd0:    word_d[INSTR_W-1:24] = IN_DATA[INSTR_W-25:0];
                        2'd1:    word_d[23:16]        = IN_DATA;
                        2'd2:    word_d[15:8]         = IN_DATA;
                        default: word_d[7:0]          = IN_DATA;
                    endcase
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d    = WRITE;
                        in_ready_d = 1'b0;
                        im_we_d    = 1'b1;
                        im_addr_d  = BASE_ADDR + idx_q;
                        im_wdata_d = word_d;
                    end
                end
            end
            WRITE: begin
                idx_d = idx_inc;
                if (idx_inc == ADDR_W'(count_q)) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    cpu_start_d = 1'b1;
                end else begin
                    state_d    = DATA;
                    in_ready_d = 1'b1;
                    bcnt_d     = 2'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            count_q     <= '0;
            idx_q       <= '0;
            bcnt_q      <= '0;
            word_q      <= '0;
            in_ready_q  <= 1'b0;
            im_we_q     <= 1'b0;
            im_addr_q   <= '0;
            im_wdata_q  <= '0;
            cpu_start_q <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            bcnt_q      <= bcnt_d;
            word_q      <= word_d;
            in_ready_q  <= in_ready_d;
            im_we_q     <= im_we_d;
            im_addr_q   <= im_addr_d;
            im_wdata_q  <= im_wdata_d;
            cpu_start_q <= cpu_start_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

    assign IN_READY  = in_ready_q;
    assign IM_WE     = im_we_q;
    assign IM_ADDR   = im_addr_q;
    assign IM_WDATA  = im_wdata_q;
    assign CPU_START = cpu_start_q;
    assign BUSY      = busy_q;
    assign ERROR     = error_q;
    assign WORD_CNT  = idx_q;

endmodule
